// File: rtl/lcd_bus_controller_if.sv
// Data-memory store/status bus seen by the LCD controller.
// The CPU side drives the store strobe, address and data; the controller returns status.
interface lcd_bus_controller_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] StatusData;

  modport master (output MemWriteM, ALUResultM, WriteDataM, input StatusData);
  modport slave  (input MemWriteM, ALUResultM, WriteDataM, output StatusData);
endinterface

// File: rtl/lcd_bus_controller.sv
// Memory-mapped HD44780-style LCD controller: queues command/data stores in a FIFO
// and replays each entry onto the LCD pins with setup, enable pulse, hold and execution wait.
module lcd_bus_controller #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          SETUP_CYC  = 2,
  parameter int          PULSE_CYC  = 12,
  parameter int          HOLD_CYC   = 2,
  parameter int          EXEC_CYC   = 2000,
  parameter int          CLEAR_CYC  = 82000,
  parameter logic [31:0] DATA_ADDR  = 32'h8A0,
  parameter logic [31:0] CMD_ADDR   = 32'h8B0,
  parameter logic [31:0] STAT_ADDR  = 32'h8C0
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_bus_controller_if.slave  bus,
  output logic [7:0]           LCD_DATA,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_EN
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] EXEC_LD  = TMR_W'(EXEC_CYC - 1);
  localparam logic [TMR_W-1:0] CLEAR_LD = TMR_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             push_req, push, drop, pop, stat_sel, stat_wr, long_wait, busy;
  logic             unused_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign stat_sel  = (bus.ALUResultM == STAT_ADDR);
  assign stat_wr   = bus.MemWriteM && stat_sel;
  assign push_req  = bus.MemWriteM && ((bus.ALUResultM == DATA_ADDR) || (bus.ALUResultM == CMD_ADDR));
  // Fullness uses the registered count, so a same-cycle pop never makes room for a push.
  assign push      = push_req && (cnt != DEPTH_C);
  assign drop      = push_req && (cnt == DEPTH_C);
  assign pop       = (state == S_IDLE) && (cnt != '0);
  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign long_wait = !LCD_RS && (LCD_DATA[7:2] == 6'd0) && (LCD_DATA != 8'd0);
  assign unused_wdata = ^bus.WriteDataM[31:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (stat_wr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {(bus.ALUResultM == DATA_ADDR), bus.WriteDataM[7:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'd0;
    end else if (pop) begin
      {LCD_RS, LCD_DATA} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      S_IDLE: begin
        if (cnt != '0) begin
          state_nxt = S_SETUP;
          tmr_nxt   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (tmr == '0) begin
          state_nxt = S_PULSE;
          tmr_nxt   = PULSE_LD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_PULSE: begin
        if (tmr == '0) begin
          state_nxt = S_HOLD;
          tmr_nxt   = HOLD_LD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_HOLD: begin
        if (tmr == '0) begin
          state_nxt = S_EXEC;
          tmr_nxt   = long_wait ? CLEAR_LD : EXEC_LD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_EXEC: begin
        if (tmr == '0) state_nxt = S_IDLE;
        else           tmr_nxt   = tmr - 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    LCD_EN         = (state == S_PULSE);
    LCD_RW         = 1'b0;
    busy           = (state != S_IDLE) || (cnt != '0);
    bus.StatusData = 32'd0;
    if (stat_sel) bus.StatusData = {24'd0, 4'(cnt), 2'b00, ovf, busy};
  end

endmodule

// File: tb/tb_lcd_bus_controller.sv
// Randomized scoreboard bench for lcd_bus_controller against a queue-based timing model.
`timescale 1ns/1ps
module tb_lcd_bus_controller;
  localparam int          FIFO_DEPTH = 8;
  localparam int          SETUP_CYC  = 2;
  localparam int          PULSE_CYC  = 12;
  localparam int          HOLD_CYC   = 2;
  localparam int          EXEC_CYC   = 20;
  localparam int          CLEAR_CYC  = 60;
  localparam logic [31:0] DATA_ADDR  = 32'h8A0;
  localparam logic [31:0] CMD_ADDR   = 32'h8B0;
  localparam logic [31:0] STAT_ADDR  = 32'h8C0;
  localparam int          BUDGET     = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN;

  lcd_bus_controller_if bus();

  lcd_bus_controller #(
    .FIFO_DEPTH(FIFO_DEPTH), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
    .HOLD_CYC(HOLD_CYC), .EXEC_CYC(EXEC_CYC), .CLEAR_CYC(CLEAR_CYC),
    .DATA_ADDR(DATA_ADDR), .CMD_ADDR(CMD_ADDR), .STAT_ADDR(STAT_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] e;
    int         rise;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] mq[$];
  int         m_rem = 0;
  bit         m_ovf = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wait_cyc(input logic [8:0] e);
    if (!e[8] && (e[7:0] == 8'h01 || e[7:0] == 8'h02 || e[7:0] == 8'h03)) return CLEAR_CYC;
    return EXEC_CYC;
  endfunction

  // Reference model: a queue of pending entries plus the number of edges the
  // output engine stays occupied after each pop.
  always @(posedge clk) begin
    int   pre_size;
    bit   req;
    exp_t x;
    cyc++;
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      pre_size = mq.size();
      req = bus.MemWriteM && (bus.ALUResultM == DATA_ADDR || bus.ALUResultM == CMD_ADDR);
      if (m_rem > 0) m_rem--;
      else if (pre_size != 0) begin
        x.e    = mq.pop_front();
        x.rise = cyc + SETUP_CYC;
        exp_q.push_back(x);
        m_rem  = SETUP_CYC + PULSE_CYC + HOLD_CYC + wait_cyc(x.e);
      end
      if (req) begin
        if (pre_size < FIFO_DEPTH) mq.push_back({bus.ALUResultM == DATA_ADDR, bus.WriteDataM[7:0]});
        else m_ovf = 1'b1;
      end else if (bus.MemWriteM && bus.ALUResultM == STAT_ADDR) begin
        m_ovf = 1'b0;
      end
    end
  end

  // Monitor: every EN pulse consumes one expected entry.
  initial begin : monitor
    bit         prev_en;
    int         width;
    logic [8:0] cur;
    exp_t       x;
    prev_en = 1'b0;
    width   = 0;
    cur     = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_en = 1'b0;
        width   = 0;
      end else begin
        if (LCD_EN && !prev_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {LCD_RS, LCD_DATA}, 32'hFFFF_FFFF);
          end else begin
            x = exp_q.pop_front();
            chk("lcd_byte", {23'd0, LCD_RS, LCD_DATA}, {23'd0, x.e});
            chk("en_rise_cycle", cyc, x.rise);
          end
          cur   = {LCD_RS, LCD_DATA};
          width = 1;
        end else if (LCD_EN) begin
          width++;
          chk("pulse_stable", {LCD_RS, LCD_DATA}, cur);
        end else if (prev_en) begin
          chk("pulse_width", width, PULSE_CYC);
        end
        prev_en = LCD_EN;
      end
    end
  end

  task automatic check_status(input string name);
    logic [31:0] e;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = STAT_ADDR;
    #1;
    e = {24'd0, 4'(mq.size()), 2'b00, m_ovf, (m_rem != 0 || mq.size() != 0)};
    chk(name, bus.StatusData, e);
  endtask

  // One bus cycle: check status against the model, then present a store (or idle).
  task automatic step(input bit we, input logic [31:0] addr, input logic [7:0] d);
    @(negedge clk);
    check_status("status");
    bus.MemWriteM  = we;
    bus.ALUResultM = addr;
    bus.WriteDataM = {24'($urandom), d};
    if (addr != STAT_ADDR) begin
      #1;
      chk("status_unselected", bus.StatusData, 32'd0);
    end
  endtask

  task automatic read_status(output logic [31:0] s);
    @(negedge clk);
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = STAT_ADDR;
    #1;
    s = bus.StatusData;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || m_rem != 0) && n < BUDGET) begin
      step(1'b0, 32'h0, 8'h00);
      n++;
    end
    chk("drain_in_budget", {31'd0, n < BUDGET}, 32'd1);
    step(1'b0, 32'h0, 8'h00);
  endtask

  function automatic logic [7:0] rand_cmd();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(1, 3));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] s;
    int          n;
    int          r;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = 32'h0;
    bus.WriteDataM = 32'h0;
    repeat (3) @(negedge clk);
    bus.ALUResultM = STAT_ADDR;
    #1;
    chk("reset_status", bus.StatusData, 32'd0);
    chk("reset_en", {31'd0, LCD_EN}, 32'd0);
    chk("reset_rs", {31'd0, LCD_RS}, 32'd0);
    chk("reset_rw", {31'd0, LCD_RW}, 32'd0);
    chk("reset_data", {24'd0, LCD_DATA}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single data byte
    step(1'b1, DATA_ADDR, 8'h41);
    read_status(s);
    chk("single_pending", s, 32'h0000_0011);
    drain();
    read_status(s);
    chk("single_done", s, 32'd0);

    // Clear command followed by a queued command
    step(1'b1, CMD_ADDR, 8'h01);
    step(1'b1, CMD_ADDR, 8'h38);
    read_status(s);
    chk("queued_cmd_count", s, 32'h0000_0011);
    repeat (40) step(1'b0, 32'h0, 8'h00);
    read_status(s);
    chk("still_queued_during_clear", s, 32'h0000_0011);
    drain();

    // Overflow: ten back-to-back data stores
    for (int i = 0; i < 10; i++) step(1'b1, DATA_ADDR, 8'($urandom_range(0, 255)));
    read_status(s);
    chk("ovf_peak", s, 32'h0000_0083);
    repeat (10) step(1'b0, 32'h0, 8'h00);
    step(1'b1, STAT_ADDR, 8'h00);
    read_status(s);
    chk("ovf_cleared", s & 32'h2, 32'd0);
    chk("still_draining", s & 32'h1, 32'd1);
    drain();

    // Pointer wrap: three batches of six
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 1) == 1) step(1'b1, DATA_ADDR, 8'($urandom_range(0, 255)));
        else step(1'b1, CMD_ADDR, rand_cmd());
      end
      drain();
    end
    read_status(s);
    chk("wrap_done", s, 32'd0);

    // Ignored traffic
    step(1'b1, 32'h800, 8'h55);
    step(1'b1, 32'h8A4, 8'hAA);
    read_status(s);
    chk("ignored_no_push", s, 32'd0);

    // Random mixed traffic
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: step(1'b1, DATA_ADDR, 8'($urandom_range(0, 255)));
        3, 4:    step(1'b1, CMD_ADDR, rand_cmd());
        5:       step(1'b1, STAT_ADDR, 8'h00);
        6:       step(1'b1, 32'h800, 8'h12);
        default: step(1'b0, 32'h0, 8'h00);
      endcase
    end
    drain();

    // Reset in the middle of an enable pulse
    step(1'b1, DATA_ADDR, 8'h5A);
    step(1'b1, DATA_ADDR, 8'h6B);
    n = 0;
    while (!LCD_EN && n < 50) begin
      step(1'b0, 32'h0, 8'h00);
      n++;
    end
    chk("pulse_seen_before_reset", {31'd0, LCD_EN}, 32'd1);
    repeat (3) step(1'b0, 32'h0, 8'h00);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_drops_en", {31'd0, LCD_EN}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    read_status(s);
    chk("status_after_reset", s, 32'd0);
    chk("data_after_reset", {23'd0, LCD_RS, LCD_DATA}, 32'd0);
    repeat (40) step(1'b0, 32'h0, 8'h00);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("rw_low", {31'd0, LCD_RW}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
